// File: rtl/i2si_sample_fifo_if.sv
// i2si_sample_fifo_if
// Groups the deserializer input, register-file controls, consumer handshake
// and status outputs of the I2S input sample FIFO.
//   master : drives rf_i2si_en, i2si_lft/rgt/xfc, rf_i2si_wm, rf_i2si_stclr,
//            rd_req; observes rd_lft/rgt/vld, fifo_cnt/empty/full, ovf/udf/irq
//   slave  : the FIFO itself (directions mirrored)
interface i2si_sample_fifo_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 3
);
    logic          rf_i2si_en;
    logic [DW-1:0] i2si_lft;
    logic [DW-1:0] i2si_rgt;
    logic          i2si_xfc;
    logic [AW:0]   rf_i2si_wm;
    logic          rf_i2si_stclr;
    logic          rd_req;
    logic [DW-1:0] rd_lft;
    logic [DW-1:0] rd_rgt;
    logic          rd_vld;
    logic [AW:0]   fifo_cnt;
    logic          fifo_empty;
    logic          fifo_full;
    logic          i2si_ovf;
    logic          i2si_udf;
    logic          i2si_irq;

    modport master (
        output rf_i2si_en, i2si_lft, i2si_rgt, i2si_xfc, rf_i2si_wm,
               rf_i2si_stclr, rd_req,
        input  rd_lft, rd_rgt, rd_vld, fifo_cnt, fifo_empty, fifo_full,
               i2si_ovf, i2si_udf, i2si_irq
    );

    modport slave (
        input  rf_i2si_en, i2si_lft, i2si_rgt, i2si_xfc, rf_i2si_wm,
               rf_i2si_stclr, rd_req,
        output rd_lft, rd_rgt, rd_vld, fifo_cnt, fifo_empty, fifo_full,
               i2si_ovf, i2si_udf, i2si_irq
    );
endinterface

// File: rtl/i2si_sample_fifo.sv
// i2si_sample_fifo
// Stores stereo pairs {left,right} from the I2S deserializer on each
// transfer-complete pulse and hands them to a consumer via rd_req/rd_vld
// with one cycle of read latency. Reports occupancy, watermark irq and
// sticky overflow/underflow.
// Ports:
//   clk  : master clock
//   rst  : synchronous active-high reset
//   bus  : i2si_sample_fifo_if.slave (inputs, read port and status)
module i2si_sample_fifo #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    i2si_sample_fifo_if.slave    bus
);
    localparam int unsigned DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            empty_q, empty_d;
    logic            full_q, full_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;
    logic            irq_q, irq_d;
    logic            rd_vld_q, rd_vld_d;
    logic [DW-1:0]   rd_lft_q, rd_lft_d;
    logic [DW-1:0]   rd_rgt_q, rd_rgt_d;
    logic [2*DW-1:0] mem_q [DEPTH];
    logic [2*DW-1:0] mem_d [DEPTH];

    logic            push_req, pop_req, push_ok, pop_ok;
    logic [2*DW-1:0] rd_word;

    always_comb begin
        push_req = bus.i2si_xfc & bus.rf_i2si_en;
        pop_req  = bus.rd_req & bus.rf_i2si_en;
        // Empty test uses the registered count: a same-cycle push is never
        // forwarded to the read port.
        pop_ok   = pop_req & (cnt_q != '0);
        // When full, a same-cycle pop frees the slot being written
        // (wptr == rptr), and the read takes the old contents first.
        push_ok  = push_req & (~full_q | pop_ok);
        rd_word  = mem_q[rptr_q];

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wptr_q] = {bus.i2si_lft, bus.i2si_rgt};
        end

        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        rd_vld_d = 1'b0;
        rd_lft_d = rd_lft_q;
        rd_rgt_d = rd_rgt_q;

        if (!bus.rf_i2si_en) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_ok) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop_ok) begin
                rptr_d   = rptr_q + 1'b1;
                rd_vld_d = 1'b1;
                rd_lft_d = rd_word[2*DW-1:DW];
                rd_rgt_d = rd_word[DW-1:0];
            end
            cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end

        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == FULL_CNT);

        // Set wins over a same-cycle clear.
        ovf_d = (push_req & full_q & ~pop_ok) | (ovf_q & ~bus.rf_i2si_stclr);
        udf_d = (pop_req & (cnt_q == '0))     | (udf_q & ~bus.rf_i2si_stclr);

        irq_d = bus.rf_i2si_en & (bus.rf_i2si_wm != '0) & (cnt_d >= bus.rf_i2si_wm);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            irq_q    <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_lft_q <= '0;
            rd_rgt_q <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            irq_q    <= irq_d;
            rd_vld_q <= rd_vld_d;
            rd_lft_q <= rd_lft_d;
            rd_rgt_q <= rd_rgt_d;
        end
    end

    // Storage has no reset; contents are only observable after a push.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.rd_lft     = rd_lft_q;
    assign bus.rd_rgt     = rd_rgt_q;
    assign bus.rd_vld     = rd_vld_q;
    assign bus.fifo_cnt   = cnt_q;
    assign bus.fifo_empty = empty_q;
    assign bus.fifo_full  = full_q;
    assign bus.i2si_ovf   = ovf_q;
    assign bus.i2si_udf   = udf_q;
    assign bus.i2si_irq   = irq_q;
endmodule
